// File: rtl/ring_delay_line.sv
// ring_delay_line: sample-count delay line built on a circular memory.
// Each accepted sample is re-emitted exactly D accepted samples later.
// Gaps in din_valid stall both pointers, so alignment survives stalls.
module ring_delay_line #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cfg_delay,
  input  logic              cfg_load,
  input  logic [WIDTH-1:0]  din,
  input  logic              din_valid,
  output logic [WIDTH-1:0]  dout,
  output logic              dout_valid,
  output logic              filling,
  output logic              running
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_delay;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_fill_cnt;
  logic [WIDTH-1:0]  r_dout;
  logic              r_dout_valid;
  logic              r_filling;
  logic              r_running;
  logic [WIDTH-1:0]  r_mem [DEPTH];

  logic              w_accept;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [ADDR_W-1:0] w_fill_inc;

  // A sample is stored only outside IDLE and only when no reload pre-empts it.
  assign w_accept   = din_valid && !cfg_load && (r_state != ST_IDLE);
  // The read trails the write by D; natural ADDR_W-bit wrap gives the modulo.
  assign w_rd_addr  = r_wr_ptr - r_delay;
  assign w_fill_inc = r_fill_cnt + PTR_ONE;

  // Next-state logic: a reload wins in every state, otherwise FILL waits for the D-th sample.
  always_comb begin
    w_state_nxt = r_state;
    if (cfg_load) begin
      if (cfg_delay == {ADDR_W{1'b0}}) begin
        w_state_nxt = ST_RUN;
      end else begin
        w_state_nxt = ST_FILL;
      end
    end else begin
      case (r_state)
        ST_IDLE: w_state_nxt = ST_IDLE;
        ST_FILL: begin
          if (din_valid && (w_fill_inc == r_delay)) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_state_nxt = ST_FILL;
          end
        end
        ST_RUN:  w_state_nxt = ST_RUN;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Control state, pointers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_delay      <= {ADDR_W{1'b0}};
      r_wr_ptr     <= {ADDR_W{1'b0}};
      r_fill_cnt   <= {ADDR_W{1'b0}};
      r_dout       <= {WIDTH{1'b0}};
      r_dout_valid <= 1'b0;
      r_filling    <= 1'b0;
      r_running    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_filling    <= (w_state_nxt == ST_FILL);
      r_running    <= (w_state_nxt == ST_RUN);
      r_dout_valid <= w_accept && (r_state == ST_RUN);
      if (cfg_load) begin
        r_delay    <= cfg_delay;
        r_wr_ptr   <= {ADDR_W{1'b0}};
        r_fill_cnt <= {ADDR_W{1'b0}};
      end else if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
        if (r_fill_cnt != r_delay) begin
          r_fill_cnt <= w_fill_inc;
        end
        if (r_state == ST_RUN) begin
          // With D = 0 the read would hit the slot being written, so bypass it.
          if (r_delay == {ADDR_W{1'b0}}) begin
            r_dout <= din;
          end else begin
            r_dout <= r_mem[w_rd_addr];
          end
        end
      end
    end
  end

  // Sample storage; not reset, the fill sequence makes every read location valid.
  always_ff @(posedge clk) begin
    if (!rst && w_accept) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign filling    = r_filling;
  assign running    = r_running;

endmodule

// File: tb/tb_ring_delay_line.sv
// Testbench for ring_delay_line: directed vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_ring_delay_line;

  localparam int WIDTH  = 16;
  localparam int ADDR_W = 6;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] cfg_delay;
  logic              cfg_load;
  logic [WIDTH-1:0]  din;
  logic              din_valid;
  logic [WIDTH-1:0]  dout;
  logic              dout_valid;
  logic              filling;
  logic              running;

  int total = 0;
  int bad   = 0;

  ring_delay_line #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_delay  (cfg_delay),
    .cfg_load   (cfg_load),
    .din        (din),
    .din_valid  (din_valid),
    .dout       (dout),
    .dout_valid (dout_valid),
    .filling    (filling),
    .running    (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: history of accepted samples since the last reload.
  logic [WIDTH-1:0] m_hist [$];
  bit               m_armed = 1'b0;
  int               m_d     = 0;
  int               m_cnt   = 0;
  bit               m_dv    = 1'b0;
  logic [WIDTH-1:0] m_dout  = '0;

  typedef struct {
    bit               rst;
    bit               load;
    logic [ADDR_W-1:0] dly;
    bit               dv;
    logic [WIDTH-1:0] d;
    bit               e_dv;
    logic [WIDTH-1:0] e_dout;
    bit               e_fill;
    bit               e_run;
  } vec_t;

  vec_t tbl [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic addv(input bit r, input bit l, input int dl, input bit v, input int d,
                      input bit edv, input int edo, input bit ef, input bit er);
    vec_t x;
    x.rst = r; x.load = l; x.dly = dl[ADDR_W-1:0]; x.dv = v; x.d = d[WIDTH-1:0];
    x.e_dv = edv; x.e_dout = edo[WIDTH-1:0]; x.e_fill = ef; x.e_run = er;
    tbl.push_back(x);
  endtask

  // One clock: drive inputs, advance the model on the edge, settle 1 time unit after it.
  task automatic apply(input bit r, input bit l, input int dl, input bit v, input int d);
    rst = r; cfg_load = l; cfg_delay = dl[ADDR_W-1:0]; din_valid = v; din = d[WIDTH-1:0];
    @(posedge clk);
    if (r) begin
      m_armed = 1'b0; m_d = 0; m_cnt = 0; m_dv = 1'b0; m_dout = '0;
      m_hist.delete();
    end else if (l) begin
      m_armed = 1'b1; m_d = dl; m_cnt = 0; m_dv = 1'b0;
      m_hist.delete();
    end else if (m_armed && v) begin
      m_hist.push_back(d[WIDTH-1:0]);
      if (m_cnt >= m_d) begin
        m_dout = m_hist[m_cnt - m_d];
        m_dv   = 1'b1;
      end else begin
        m_dv = 1'b0;
      end
      m_cnt++;
    end else begin
      m_dv = 1'b0;
    end
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".dv"},   {31'd0, dout_valid}, {31'd0, m_dv});
    chk({tag, ".dout"}, {16'd0, dout},       {16'd0, m_dout});
    chk({tag, ".fill"}, {31'd0, filling},    {31'd0, (m_armed && (m_cnt < m_d))});
    chk({tag, ".run"},  {31'd0, running},    {31'd0, (m_armed && (m_cnt >= m_d))});
  endtask

  task automatic step(input string tag, input bit r, input bit l, input int dl,
                      input bit v, input int d);
    apply(r, l, dl, v, d);
    chk_model(tag);
  endtask

  initial begin
    int n_out;
    int first_idx;
    logic [WIDTH-1:0] first_val;
    int pat [7];
    int val [7];
    int vi;

    rst = 1'b1; cfg_load = 1'b0; cfg_delay = '0; din_valid = 1'b0; din = '0;

    // Directed table: reset with din_valid toggling, IDLE ignore, D=3 over 1..10.
    addv(1, 0, 0, 1, 7,  0, 0, 0, 0);
    addv(1, 0, 0, 0, 8,  0, 0, 0, 0);
    addv(1, 0, 0, 1, 9,  0, 0, 0, 0);
    addv(0, 0, 0, 1, 5,  0, 0, 0, 0);
    addv(0, 1, 3, 0, 0,  0, 0, 1, 0);
    addv(0, 0, 0, 1, 1,  0, 0, 1, 0);
    addv(0, 0, 0, 1, 2,  0, 0, 1, 0);
    addv(0, 0, 0, 1, 3,  0, 0, 0, 1);
    for (int k = 4; k <= 10; k++) addv(0, 0, 0, 1, k, 1, k - 3, 0, 1);
    addv(0, 0, 0, 0, 77, 0, 7, 0, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].rst, tbl[i].load, int'(tbl[i].dly), tbl[i].dv, int'(tbl[i].d));
      chk($sformatf("tbl%0d.dv", i),   {31'd0, dout_valid}, {31'd0, tbl[i].e_dv});
      chk($sformatf("tbl%0d.dout", i), {16'd0, dout},       {16'd0, tbl[i].e_dout});
      chk($sformatf("tbl%0d.fill", i), {31'd0, filling},    {31'd0, tbl[i].e_fill});
      chk($sformatf("tbl%0d.run", i),  {31'd0, running},    {31'd0, tbl[i].e_run});
    end

    // D=0 bypass: running right after the load, dout = din one cycle later.
    step("d0.load", 0, 1, 0, 1, 16'h1111);
    chk("d0.running", {31'd0, running}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      step("d0.run", 0, 0, 0, 1, 16'hA000 + i);
      chk("d0.bypass", {16'd0, dout}, 32'hA000 + i);
    end

    // D=2 with stalls: pattern 1,0,0,1,1,0,1 carrying 10,20,30,40.
    pat = '{1, 0, 0, 1, 1, 0, 1};
    val = '{10, 0, 0, 20, 30, 0, 40};
    step("d2.load", 0, 1, 2, 0, 0);
    for (int i = 0; i < 7; i++) begin
      step("d2.seq", 0, 0, 0, pat[i] != 0, (pat[i] != 0) ? val[i] : 999 + i);
    end
    chk("d2.last", {16'd0, dout}, 32'd20);

    // D=63 across pointer wraps: first output 0 after sample 63, 137 outputs in total.
    step("d63.load", 0, 1, 63, 0, 0);
    n_out = 0; first_idx = -1; first_val = '1;
    for (int i = 0; i < 200; i++) begin
      step("d63.run", 0, 0, 0, 1, i);
      if (dout_valid) begin
        if (first_idx < 0) begin
          first_idx = i;
          first_val = dout;
        end
        n_out++;
      end
    end
    chk("d63.first_idx", first_idx, 32'd63);
    chk("d63.first_val", {16'd0, first_val}, 32'd0);
    chk("d63.count", n_out, 32'd137);

    // D=4 for 10 samples, reload D=1 on a valid cycle (dropped), then 5..9.
    step("rl.load", 0, 1, 4, 0, 0);
    for (int i = 0; i < 10; i++) step("rl.a", 0, 0, 0, 1, i);
    step("rl.reload", 0, 1, 1, 1, 16'hDEAD);
    chk("rl.dv_after_load", {31'd0, dout_valid}, 32'd0);
    chk("rl.filling", {31'd0, filling}, 32'd1);
    for (int i = 5; i <= 9; i++) begin
      step("rl.b", 0, 0, 0, 1, i);
      if (i > 5) chk("rl.dout", {16'd0, dout}, i - 1);
    end

    // rst mid-RUN, with a simultaneous cfg_load and din_valid; then din ignored in IDLE.
    step("rst.hit", 1, 1, 5, 1, 16'h5555);
    chk("rst.idle_run", {31'd0, running}, 32'd0);
    chk("rst.dout", {16'd0, dout}, 32'd0);
    for (int i = 0; i < 5; i++) step("rst.ignore", 0, 0, 0, 1, 16'h7000 + i);

    // Randomized traffic: random delays, random stalls, occasional mid-stream reloads.
    for (int seg = 0; seg < 12; seg++) begin
      step("rnd.load", 0, 1, $urandom_range(63, 0), ($urandom_range(1, 0) != 0), $urandom);
      for (int c = 0; c < 250; c++) begin
        if ($urandom_range(199, 0) == 0) begin
          step("rnd.reload", 0, 1, $urandom_range(63, 0), 1, $urandom);
        end else begin
          vi = $urandom;
          step("rnd.run", 0, 0, 0, ($urandom_range(9, 0) < 7), vi);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ring_delay_line.md
# ring_delay_line

Sample-count delay line for the CNN datapath. It re-emits each valid sample exactly `D` valid samples later, where `D` is set at run time. Storage is a circular memory with separate write and read pointers, rather than a clock-count shift register. Feature-map row buffers and window alignment sit behind it: upstream stalls (gaps in `din_valid`) are absorbed without breaking sample alignment.

## Interface
- `WIDTH`, 16, sample width in bits
- `ADDR_W`, 6, memory address width; depth = 2^ADDR_W; maximum delay = 2^ADDR_W - 1
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `cfg_delay`  in  ADDR_W  delay `D` in valid samples; sampled only when `cfg_load` = 1
- `cfg_load`  in  1  one-cycle pulse: latch `cfg_delay`, flush history, start filling
- `din`  in  WIDTH  input sample
- `din_valid`  in  1  `din` is accepted this cycle (not accepted in IDLE)
- `dout`  out  WIDTH  delayed sample
- `dout_valid`  out  1  `dout` is valid this cycle (one-cycle pulse per output)
- `filling`  out  1  high in FILL state
- `running`  out  1  high in RUN state

## Operation
- State machine: IDLE, FILL, RUN.
- IDLE
  - Entered on reset.
  - `din_valid` is ignored.
  - `cfg_load` latches `D`, clears `wr_ptr` and `fill_cnt`, then goes to RUN if `D` = 0, else to FILL.
- FILL
  - Each `din_valid` writes `mem[wr_ptr]`, increments `wr_ptr` modulo 2^ADDR_W, and increments `fill_cnt`.
  - When the accepted sample makes `fill_cnt` = `D`, the next state is RUN.
  - No output is produced in FILL.
- RUN
  - Each `din_valid` writes `mem[wr_ptr]`, increments `wr_ptr`, and reads the pre-write contents of `mem[(wr_ptr - D) mod 2^ADDR_W]`.
  - The read result is registered into `dout`.
  - When `D` = 0, the read address equals the write address; `din` is bypassed to `dout`, and the read-during-write memory value is never used.
- `cfg_load` in any state: same action as in IDLE. It has priority over a simultaneous `din_valid`; that sample is discarded and not written.
- Pointer arithmetic is ADDR_W bits unsigned with natural wrap. `fill_cnt` is ADDR_W bits and saturates at `D`.
- Memory contents are not reset. Correct output relies only on the fill sequence.

## Timing
- Reset values: state IDLE, `wr_ptr` = 0, `fill_cnt` = 0, `D` = 0, `dout` = 0, `dout_valid` = 0, `filling` = 0, `running` = 0.
- Latency: a `din_valid` cycle in RUN produces `dout`/`dout_valid` on the next cycle.
- `dout` holds its last value between pulses.
- Gaps in `din_valid` produce gaps in `dout_valid`; sample alignment is preserved.
- In RUN, the k-th accepted sample after `cfg_load` (counting from 0) outputs sample k - D.
- State transitions:
  - `filling` and `running` reflect the registered state; they change in the cycle after the triggering edge.
  - FILL to RUN takes effect on the edge that accepts the D-th sample.
  - The (D+1)-th sample, even if it arrives on the very next cycle, is processed in RUN.
- `cfg_load` mid-run: `dout_valid` is 0 in the following cycle, except that a pulse already registered from the prior cycle still appears. Output resumes after `D` new samples.
- `rst` mid-operation overrides everything, including `cfg_load`, in the same cycle.

## Test plan
- Reset with `din_valid` toggling -> `dout_valid`, `filling`, and `running` stay 0; `dout` = 0.
- `cfg_load`, `D` = 3; feed 1..10 back-to-back -> `filling` for 3 samples; `dout` = 1..7, each one cycle after the inputs 4..10 are accepted.
- `D` = 0 -> `running` in the cycle after `cfg_load`; `dout` = `din` one cycle after each `din_valid` (bypass path).
- `D` = 2 with `din_valid` pattern 1,0,0,1,1,0,1 carrying values 10,20,30,40 -> `dout` 10 then 20, each one cycle after 30 and 40 are accepted.
- `D` = 63, feed 0..199 -> the first output is 0, one cycle after sample 63; all 137 outputs equal input - 63 across pointer wraps.
- Run `D` = 4 for 10 samples, then `cfg_load` `D` = 1 coinciding with `din_valid`, then 5..9 -> that coincident sample is dropped; `filling` for 1 sample; `dout` = 5..8.
- Assert `rst` mid-RUN -> the next cycle shows IDLE, `dout_valid` = 0, and `din` is ignored until `cfg_load`.
